tcam_lookup_engine: RTL

TCAM_LOOKUP_ENGINE -- requirements
Module: tcam_lookup_engine

---
 rtl/tcam_lookup_engine_if.sv | 39 +++
 rtl/tcam_lookup_engine.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tcam_lookup_engine_if.sv
// Command/response bundle for the TCAM lookup engine.
// Master issues commands and consumes responses; slave is the engine.
interface tcam_lookup_engine_if #(
    parameter int KEY_WIDTH  = 8,
    parameter int ID_WIDTH   = 4,
    parameter int ADDR_WIDTH = 4
);

    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [2:0]            cmd_op;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [KEY_WIDTH-1:0]  cmd_key;
    logic [KEY_WIDTH-1:0]  cmd_mask;
    logic [ID_WIDTH-1:0]   cmd_data;

    logic                  rsp_valid;
    logic                  rsp_ready;
    logic                  rsp_hit;
    logic                  rsp_multi;
    logic [ADDR_WIDTH-1:0] rsp_addr;
    logic [ID_WIDTH-1:0]   rsp_data;
    logic                  rsp_err;

    modport master (
        output cmd_valid, cmd_op, cmd_addr, cmd_key, cmd_mask, cmd_data,
        output rsp_ready,
        input  cmd_ready,
        input  rsp_valid, rsp_hit, rsp_multi, rsp_addr, rsp_data, rsp_err
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_addr, cmd_key, cmd_mask, cmd_data,
        input  rsp_ready,
        output cmd_ready,
        output rsp_valid, rsp_hit, rsp_multi, rsp_addr, rsp_data, rsp_err
    );

endinterface

// File: rtl/tcam_lookup_engine.sv
// Ternary CAM in flops with a single-outstanding command FSM.
// Lowest matching index wins a LOOKUP; FLUSH walks one entry per cycle.
module tcam_lookup_engine #(
    parameter int KEY_WIDTH  = 8,
    parameter int ID_WIDTH   = 4,
    parameter int WORDS      = 16,
    parameter int ADDR_WIDTH = $clog2(WORDS)
) (
    input  logic                  clk,
    input  logic                  rst,
    tcam_lookup_engine_if.slave   bus,
    output logic [15:0]           stat_lookups,
    output logic [15:0]           stat_hits
);

    localparam logic [2:0] OP_NOP    = 3'd0;
    localparam logic [2:0] OP_WRITE  = 3'd1;
    localparam logic [2:0] OP_READ   = 3'd2;
    localparam logic [2:0] OP_FLUSH  = 3'd3;
    localparam logic [2:0] OP_LOOKUP = 3'd4;
    localparam logic [2:0] OP_INVAL  = 3'd5;

    localparam logic [ADDR_WIDTH-1:0] LAST  = ADDR_WIDTH'(WORDS - 1);
    localparam logic [ADDR_WIDTH:0]   DEPTH = (ADDR_WIDTH + 1)'(WORDS);

    typedef enum logic [1:0] {
        IDLE,
        MATCH,
        FLUSH,
        RESP
    } state_t;

    state_t state;
    state_t state_nx;

    logic [KEY_WIDTH-1:0] ekey  [WORDS];
    logic [KEY_WIDTH-1:0] emask [WORDS];
    logic [ID_WIDTH-1:0]  edata [WORDS];
    logic [WORDS-1:0]     valid;

    logic [ADDR_WIDTH-1:0] flush_cnt;
    logic [KEY_WIDTH-1:0]  lk_key;
    logic [KEY_WIDTH-1:0]  lk_mask;

    logic op_write;
    logic op_read;
    logic op_flush;
    logic op_lookup;
    logic op_inval;
    logic op_ill;
    logic addr_ok;
    logic cmd_err;
    logic accept;

    logic                  lk_found;
    logic                  lk_multi;
    logic [ADDR_WIDTH-1:0] lk_idx;
    logic [ID_WIDTH-1:0]   lk_data;

    logic                  r_hit;
    logic                  r_multi;
    logic                  r_err;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [ID_WIDTH-1:0]   r_data;

    logic cmd_ready_c;
    logic rsp_valid_c;

    // Opcode decode; 6 and 7 fall into the illegal bucket.
    always_comb begin
        op_write  = 1'b0;
        op_read   = 1'b0;
        op_flush  = 1'b0;
        op_lookup = 1'b0;
        op_inval  = 1'b0;
        op_ill    = 1'b0;
        unique case (bus.cmd_op)
            OP_NOP:    ;
            OP_WRITE:  op_write  = 1'b1;
            OP_READ:   op_read   = 1'b1;
            OP_FLUSH:  op_flush  = 1'b1;
            OP_LOOKUP: op_lookup = 1'b1;
            OP_INVAL:  op_inval  = 1'b1;
            default:   op_ill    = 1'b1;
        endcase
    end

    assign accept  = bus.cmd_valid && (state == IDLE);
    assign addr_ok = {1'b0, bus.cmd_addr} < DEPTH;
    assign cmd_err = op_ill
                   || ((op_write || op_read || op_inval) && !addr_ok);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic; lookups and flushes detour before RESP.
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    unique case (1'b1)
                        op_lookup: state_nx = MATCH;
                        op_flush:  state_nx = FLUSH;
                        default:   state_nx = RESP;
                    endcase
                end
            end
            MATCH: state_nx = RESP;
            FLUSH: begin
                if (flush_cnt == LAST) begin
                    state_nx = RESP;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Handshake outputs follow the state directly.
    always_comb begin
        cmd_ready_c = (state == IDLE);
        rsp_valid_c = (state == RESP);
    end

    // Entry contents; deliberately not reset, only valid bits are.
    always_ff @(posedge clk) begin
        if (accept && op_write && !cmd_err) begin
            ekey[bus.cmd_addr]  <= bus.cmd_key;
            emask[bus.cmd_addr] <= bus.cmd_mask;
            edata[bus.cmd_addr] <= bus.cmd_data;
        end
    end

    // Lookup operand capture for the MATCH cycle.
    always_ff @(posedge clk) begin
        if (accept && op_lookup) begin
            lk_key  <= bus.cmd_key;
            lk_mask <= bus.cmd_mask;
        end
    end

    // Valid bits and the flush walker.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid     <= '0;
            flush_cnt <= '0;
        end else begin
            if (accept && !cmd_err) begin
                if (op_write) begin
                    valid[bus.cmd_addr] <= 1'b1;
                end
                if (op_inval) begin
                    valid[bus.cmd_addr] <= 1'b0;
                end
            end
            if (state == FLUSH) begin
                valid[flush_cnt] <= 1'b0;
                flush_cnt <= (flush_cnt == LAST) ? '0 : flush_cnt + 1'b1;
            end
        end
    end

    // Match lines with lowest-index priority and a second-hit flag.
    always_comb begin
        lk_found = 1'b0;
        lk_multi = 1'b0;
        lk_idx   = '0;
        lk_data  = '0;
        for (int i = 0; i < WORDS; i++) begin
            if (valid[i]
                && (((lk_key ^ ekey[i]) & emask[i] & lk_mask) == '0)) begin
                if (lk_found) begin
                    lk_multi = 1'b1;
                end else begin
                    lk_found = 1'b1;
                    lk_idx   = ADDR_WIDTH'(i);
                    lk_data  = edata[i];
                end
            end
        end
    end

    // Response register: cleared at accept, filled by READ or MATCH.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hit   <= 1'b0;
            r_multi <= 1'b0;
            r_err   <= 1'b0;
            r_addr  <= '0;
            r_data  <= '0;
        end else if (accept) begin
            r_hit   <= 1'b0;
            r_multi <= 1'b0;
            r_err   <= cmd_err;
            r_addr  <= '0;
            r_data  <= '0;
            if (op_read && !cmd_err) begin
                r_hit  <= valid[bus.cmd_addr];
                r_addr <= bus.cmd_addr;
                r_data <= edata[bus.cmd_addr];
            end
        end else if (state == MATCH) begin
            r_hit   <= lk_found;
            r_multi <= lk_multi;
            r_addr  <= lk_idx;
            r_data  <= lk_data;
        end
    end

    // Saturating lookup statistics, bumped when a result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_lookups <= '0;
            stat_hits    <= '0;
        end else if (state == MATCH) begin
            if (stat_lookups != 16'hFFFF) begin
                stat_lookups <= stat_lookups + 16'd1;
            end
            if (lk_found && (stat_hits != 16'hFFFF)) begin
                stat_hits <= stat_hits + 16'd1;
            end
        end
    end

    assign bus.cmd_ready = cmd_ready_c;
    assign bus.rsp_valid = rsp_valid_c;
    assign bus.rsp_hit   = r_hit;
    assign bus.rsp_multi = r_multi;
    assign bus.rsp_err   = r_err;
    assign bus.rsp_addr  = r_addr;
    assign bus.rsp_data  = r_data;

endmodule
